// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, the packed complex-sample type and the
// index bit-reversal helper used by the FFT reorder block.
package fft_pkg;

  localparam int DATA_WIDTH = 50;
  localparam int LOG2_N     = 3;
  localparam int N_POINTS   = 1 << LOG2_N;

  // Packed complex sample: real half in the upper bits, imaginary in the lower.
  typedef struct packed {
    logic signed [DATA_WIDTH/2-1:0] re;
    logic signed [DATA_WIDTH/2-1:0] im;
  } cplx_t;

  // Reverse the low 'bits' bits of idx.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < bits; k++) begin
      r = (r << 1) | ((idx >> k) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one frame of sample storage, single write port and an
// asynchronous read port. Contents are deliberately not reset.
module fft_reorder_bank #(
  parameter int DATA_WIDTH = 50,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_W];

  // Capture the incoming sample at its bit-reversed slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: converts bit-reversed FFT output into natural order
// using two ping-pong frame banks. While one bank drains, the other fills,
// so sustained 1 sample/cycle is possible in both directions.
// Optional macro FFT_REORDER_SCALE_EN: arithmetic right shift of each
// output half by LOG2_N (floor), i.e. a 1/N normalisation.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int LOG2_N     = fft_pkg::LOG2_N
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] signal_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  import fft_pkg::*;

  localparam logic [LOG2_N-1:0] LAST_IDX = {LOG2_N{1'b1}};

  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [LOG2_N-1:0]     wr_idx_q, wr_idx_d;
  logic [LOG2_N-1:0]     rd_idx_q, rd_idx_d;
  logic                  in_fire, out_fire, valid_int;
  logic [LOG2_N-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] rdata [2];

  // Output scaling: floor division of each half by 2**LOG2_N when enabled.
  function automatic logic [DATA_WIDTH-1:0] scale_out(input logic [DATA_WIDTH-1:0] s);
`ifdef FFT_REORDER_SCALE_EN
    logic signed [DATA_WIDTH-DATA_WIDTH/2-1:0] re;
    logic signed [DATA_WIDTH/2-1:0]            im;
    re = s[DATA_WIDTH-1:DATA_WIDTH/2];
    im = s[DATA_WIDTH/2-1:0];
    re = re >>> LOG2_N;
    im = im >>> LOG2_N;
    return {re, im};
`else
    return s;
`endif
  endfunction

  assign ready_o   = !full_q[wr_bank_q] && !rst_i;
  assign valid_int = full_q[rd_bank_q] && !rst_i;
  assign in_fire   = valid_i && ready_o;
  assign out_fire  = valid_int && ready_i;
  assign wr_addr   = LOG2_N'(bitrev(32'(wr_idx_q), 32'(LOG2_N)));

  assign valid_o  = valid_int;
  assign last_o   = valid_int && (rd_idx_q == LAST_IDX);
  assign signal_o = valid_int ? scale_out(rdata[rd_bank_q]) : '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (LOG2_N)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (in_fire && (wr_bank_q == 1'(b))),
      .waddr_i (wr_addr),
      .wdata_i (signal_i),
      .raddr_i (rd_idx_q),
      .rdata_o (rdata[b])
    );
  end

  // Pointer and full-flag updates; fill and drain always target different banks.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (in_fire) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (out_fire) begin
      rd_idx_d = rd_idx_q + 1'b1;
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  // Control state register; reset drops any partial or pending frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder: scenario tasks against a frame-level
// reference model (natural-order frames, bit-reversed presentation).
// Honours FFT_REORDER_SCALE_EN for the expected output values.
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  localparam int W  = 50;
  localparam int H  = 25;
  localparam int LG = 3;
  localparam int N  = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [W-1:0] signal_i = '0;
  logic         ready_o, valid_o, last_o;
  logic [W-1:0] signal_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic         ro, vo, lo;
  logic [W-1:0] so;

  fft_bitrev_reorder dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .signal_i (signal_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .signal_o (signal_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .last_o   (last_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge and sample the outputs
  // that the next rising edge will act on.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    rst_i = rst; valid_i = v; signal_i = d; ready_i = r;
    #1;
    ro = ready_o; vo = valid_o; so = signal_o; lo = last_o;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [W-1:0] mk(input int re, input int im);
    cplx_t c;
    c.re = H'(re);
    c.im = H'(im);
    return c;
  endfunction

  function automatic int floor_div(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [W-1:0] expect_out(input logic [W-1:0] s);
    int re, im;
    re = int'($signed(s[W-1:H]));
    im = int'($signed(s[H-1:0]));
`ifdef FFT_REORDER_SCALE_EN
    re = floor_div(re, N);
    im = floor_div(im, N);
`endif
    return mk(re, im);
  endfunction

  function automatic int brev(input int i);
    int r, x;
    r = 0; x = i;
    for (int k = 0; k < LG; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_sample();
    logic [W-1:0] x;
    x[W-1:H] = H'($urandom);
    x[H-1:0] = H'($urandom);
    return x;
  endfunction

  // Build nf random natural-order frames: inp = presentation order, exp = expected outputs.
  task automatic make_frames(input int nf, output logic [W-1:0] inp[$], output logic [W-1:0] exp[$]);
    logic [W-1:0] nat[N];
    inp = {}; exp = {};
    for (int f = 0; f < nf; f++) begin
      for (int j = 0; j < N; j++) nat[j] = rnd_sample();
      for (int k = 0; k < N; k++) inp.push_back(nat[brev(k)]);
      for (int j = 0; j < N; j++) exp.push_back(expect_out(nat[j]));
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, mk(3, 3), 1'b1);
      n_checks++; if (ro !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ro); end
      n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vo); end
      n_checks++; if (lo !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", lo); end
      n_checks++; if (so !== '0) begin n_fail++; $display("FAIL reset_signal: got %h want 0", so); end
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", ro); end
    n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", vo); end
  endtask

  task automatic test_ordering();
    logic [W-1:0] nat[N];
    for (int j = 0; j < N; j++) nat[j] = mk(j, -j);
    do_reset();
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, nat[brev(k)], 1'b1);
      n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL order_ready k=%0d: got %b want 1", k, ro); end
      n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL order_early_valid k=%0d: got %b want 0", k, vo); end
    end
    for (int j = 0; j < N; j++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      n_checks++; if (vo !== 1'b1) begin n_fail++; $display("FAIL order_valid j=%0d: got %b want 1", j, vo); end
      n_checks++; if (so !== expect_out(nat[j])) begin n_fail++; $display("FAIL order_data j=%0d: got %h want %h", j, so, expect_out(nat[j])); end
      n_checks++; if (lo !== (j == N-1)) begin n_fail++; $display("FAIL order_last j=%0d: got %b want %b", j, lo, (j == N-1)); end
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL order_drained: got %b want 0", vo); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] inp[$], exp[$];
    make_frames(4, inp, exp);
    do_reset();
    for (int c = 0; c < 44; c++) begin
      step(1'b0, c < 32, (c < 32) ? inp[c] : '0, 1'b1);
      if (c < 32) begin
        n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b want 1", c, ro); end
      end
      if (c >= 8 && c < 40) begin
        n_checks++; if (vo !== 1'b1 || so !== exp[c-8]) begin n_fail++; $display("FAIL b2b_out c=%0d: got v=%b %h want v=1 %h", c, vo, so, exp[c-8]); end
        n_checks++; if (lo !== ((c - 8) % N == N-1)) begin n_fail++; $display("FAIL b2b_last c=%0d: got %b", c, lo); end
      end
      if (c == 7 || c == 40) begin
        n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL b2b_idle c=%0d: got %b want 0", c, vo); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] inp[$], exp[$];
    int acc, got;
    logic v;
    make_frames(3, inp, exp);
    do_reset();
    acc = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      v = acc < 24;
      step(1'b0, v, v ? inp[acc] : '0, 1'b0);
      n_checks++; if (ro !== (acc < 16)) begin n_fail++; $display("FAIL bp_ready c=%0d acc=%0d: got %b want %b", c, acc, ro, (acc < 16)); end
      if (ro && v) acc++;
    end
    n_checks++; if (acc != 16) begin n_fail++; $display("FAIL bp_accepts: got %0d want 16", acc); end
    for (int c = 0; c < 80 && !(got == 24 && acc == 24); c++) begin
      v = acc < 24;
      step(1'b0, v, v ? inp[acc] : '0, 1'b1);
      if (ro && v) acc++;
      if (vo) begin
        if (got < 24) begin
          n_checks++; if (so !== exp[got]) begin n_fail++; $display("FAIL bp_data n=%0d: got %h want %h", got, so, exp[got]); end
          n_checks++; if (lo !== (got % N == N-1)) begin n_fail++; $display("FAIL bp_last n=%0d: got %b", got, lo); end
        end
        got++;
      end
    end
    n_checks++; if (got != 24 || acc != 24) begin n_fail++; $display("FAIL bp_count: got out=%0d in=%0d want 24/24", got, acc); end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL bp_extra: got valid %b want 0", vo); end
  endtask

  task automatic test_hold();
    logic [W-1:0] inp[$], exp[$];
    logic         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic         r, pv, pr, pl;
    logic [W-1:0] ps;
    int           got, t;
    make_frames(1, inp, exp);
    do_reset();
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, inp[k], 1'b1);
    got = 0; t = 0; pv = 1'b0; pr = 1'b1; pl = 1'b0; ps = '0;
    for (int c = 0; c < 40 && got < N; c++) begin
      r = pat[t % 4];
      step(1'b0, 1'b0, '0, r);
      if (pv && !pr) begin
        n_checks++; if (vo !== 1'b1 || so !== ps || lo !== pl) begin n_fail++; $display("FAIL hold c=%0d: got v=%b %h l=%b want v=1 %h l=%b", c, vo, so, lo, ps, pl); end
      end
      if (vo) begin
        t++;
        if (r) begin
          n_checks++; if (so !== exp[got]) begin n_fail++; $display("FAIL hold_data n=%0d: got %h want %h", got, so, exp[got]); end
          n_checks++; if (lo !== (got == N-1)) begin n_fail++; $display("FAIL hold_last n=%0d: got %b", got, lo); end
          got++;
        end
      end
      pv = vo; pr = r; pl = lo; ps = so;
    end
    n_checks++; if (got != N) begin n_fail++; $display("FAIL hold_count: got %0d want %0d", got, N); end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL hold_dup: got valid %b want 0", vo); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] old_inp[$], old_exp[$], inp[$], exp[$];
    int got;
    make_frames(1, old_inp, old_exp);
    make_frames(1, inp, exp);
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, old_inp[k], 1'b1);
    step(1'b1, 1'b1, old_inp[5], 1'b1);
    n_checks++; if (ro !== 1'b0) begin n_fail++; $display("FAIL mrst_ready_in_reset: got %b want 0", ro); end
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, inp[k], 1'b1);
      n_checks++; if (ro !== 1'b1) begin n_fail++; $display("FAIL mrst_ready k=%0d: got %b want 1", k, ro); end
      n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL mrst_stale_valid k=%0d: got %b want 0", k, vo); end
    end
    got = 0;
    for (int c = 0; c < 14; c++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (vo) begin
        n_checks++;
        if (got >= N || so !== exp[got]) begin n_fail++; $display("FAIL mrst_data n=%0d: got %h want %h", got, so, (got < N) ? exp[got] : '0); end
        got++;
      end
    end
    n_checks++; if (got != N) begin n_fail++; $display("FAIL mrst_count: got %0d want %0d", got, N); end
  endtask

  task automatic test_scaling();
    logic [W-1:0] want;
`ifdef FFT_REORDER_SCALE_EN
    want = mk(-2, 2);
`else
    want = mk(-9, 17);
`endif
    do_reset();
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, (k == 0) ? mk(-9, 17) : rnd_sample(), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (vo !== 1'b1 || so !== want) begin n_fail++; $display("FAIL scale: got v=%b %h want v=1 %h", vo, so, want); end
  endtask

  task automatic test_random();
    logic [W-1:0] inp[$], exp[$];
    logic [W-1:0] ps;
    logic         v, r, pv, pr;
    int           acc, got, total;
    make_frames(12, inp, exp);
    total = inp.size();
    do_reset();
    acc = 0; got = 0; pv = 1'b0; pr = 1'b1; ps = '0;
    for (int c = 0; c < 3000 && got < total; c++) begin
      v = (acc < total) && ($urandom_range(3) != 0);
      r = ($urandom_range(2) != 0);
      step(1'b0, v, v ? inp[acc] : rnd_sample(), r);
      if (v && ro) acc++;
      if (pv && !pr) begin
        n_checks++; if (vo !== 1'b1 || so !== ps) begin n_fail++; $display("FAIL rnd_hold c=%0d: got v=%b %h want %h", c, vo, so, ps); end
      end
      if (vo && r) begin
        n_checks++; if (so !== exp[got]) begin n_fail++; $display("FAIL rnd_data n=%0d: got %h want %h", got, so, exp[got]); end
        n_checks++; if (lo !== (got % N == N-1)) begin n_fail++; $display("FAIL rnd_last n=%0d: got %b", got, lo); end
        got++;
      end
      pv = vo; pr = r; ps = so;
    end
    n_checks++; if (got != total) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got, total); end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_back_to_back();
    test_backpressure();
    test_hold();
    test_mid_reset();
    test_scaling();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
